// File: rtl/crc_unfold3_frame_ctrl_pkg.sv
// Shared constants and state encoding for the 3-way unfolded CRC-5 frame controller.
package crc_unfold3_pkg;

  localparam int unsigned MSG_W = 6;
  localparam int unsigned J     = 3;
  localparam int unsigned CRC_W = 5;
  localparam logic [CRC_W-1:0] POLY = 5'h05;
  localparam logic [CRC_W-1:0] INIT = 5'h00;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OUT
  } state_t;

endpackage

// File: rtl/crc_unfold3_frame_ctrl_if.sv
// Message-in and CRC-out handshakes of the frame controller.
interface crc_unfold3_frame_ctrl_if #(
  parameter int unsigned MSG_W = 6,
  parameter int unsigned CRC_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CRC_W-1:0] crc_out;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, crc_out
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, crc_out
  );

endinterface

// File: rtl/crc_unfold3_frame_ctrl_step.sv
// Combinational J-bit step of the serial Galois LFSR, MSB of data consumed first.
module crc_unfold3_step #(
  parameter int unsigned J     = 3,
  parameter int unsigned CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = 5'h05
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [J-1:0]     data,
  output logic [CRC_W-1:0] crc_next
);

  always_comb begin
    logic [CRC_W-1:0] c;
    logic             fb;
    c  = crc_in;
    fb = 1'b0;
    for (int unsigned i = 0; i < J; i++) begin
      fb = c[CRC_W-1] ^ data[J-1-i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc_unfold3_frame_ctrl.sv
// Frame sequencer: loads a word, steps it J bits per clock through the LFSR,
// and presents the accumulated CRC after the last word of a frame.
module crc_unfold3_frame_ctrl #(
  parameter int unsigned MSG_W = crc_unfold3_pkg::MSG_W,
  parameter int unsigned J     = crc_unfold3_pkg::J,
  parameter int unsigned CRC_W = crc_unfold3_pkg::CRC_W,
  parameter logic [CRC_W-1:0] POLY = crc_unfold3_pkg::POLY,
  parameter logic [CRC_W-1:0] INIT = crc_unfold3_pkg::INIT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  crc_unfold3_frame_ctrl_if.slave  bus,
  output logic                     busy
);

  import crc_unfold3_pkg::*;

  localparam int unsigned NCHUNK = MSG_W / J;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state, state_nxt;
  logic [CRC_W-1:0] crc, crc_step;
  logic [MSG_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             last_q;
  logic             chunk_done;

  crc_unfold3_step #(
    .J     (J),
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .crc_in   (crc),
    .data     (shreg[MSG_W-1 -: J]),
    .crc_next (crc_step)
  );

  assign chunk_done  = (cnt == CNT_W'(NCHUNK - 1));
  assign bus.crc_out = crc;

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (chunk_done) state_nxt = last_q ? OUT : IDLE;
      end
      OUT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // crc survives the IDLE gap between words; only OUT handshake, flush or reset clear it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      crc    <= INIT;
      shreg  <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        crc <= INIT;
      end else begin
        case (state)
          IDLE: begin
            if (bus.in_valid) begin
              shreg  <= bus.in_data;
              last_q <= bus.in_last;
              cnt    <= '0;
            end
          end
          SHIFT: begin
            crc   <= crc_step;
            shreg <= shreg << J;
            cnt   <= cnt + 1'b1;
          end
          OUT: begin
            if (bus.out_ready) crc <= INIT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
